// File: rtl/dmem_pkg.sv
// Shared types and access helpers for the data-memory responder.
// Lane selection, load extension and store byte-enable generation live here.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Halfword lane is taken from lane[1]; word accesses ignore the lane.
   function automatic logic [31:0] ld_extend(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  funct3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'd0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'd0, h};
         F3_W:    r = word;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] st_mask(input logic [1:0] lane,
                                          input logic [2:0] funct3);
      logic [3:0] m;
      case (funct3)
         F3_B:    m = 4'b0001 << lane;
         F3_H:    m = lane[1] ? 4'b1100 : 4'b0011;
         F3_W:    m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate right-aligned store data so every enabled lane sees its bytes.
   function automatic logic [31:0] st_data(input logic [31:0] wdata,
                                           input logic [2:0]  funct3);
      logic [31:0] d;
      case (funct3)
         F3_B:    d = {4{wdata[7:0]}};
         F3_H:    d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
      logic ok;
      if (we) begin
         ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
      end else begin
         ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte write enables and combinational read.
// All words clear asynchronously on reset.
module dmem_array #(
   parameter int unsigned DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [3:0]            be,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;

   logic [31:0] mem_q [Depth];
   logic [31:0] mem_d [Depth];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               mem_d[idx][8*l +: 8] = wdata[8*l +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: valid/ready request in, held response out, with
// LATENCY wait states. Define DMEM_RSP_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 5,
   parameter int unsigned LATENCY    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam logic [3:0] CntLoad = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        commit;
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic [2:0]  c_f3;
   logic        c_range_err;
   logic        c_misalign;
   logic        c_err;
   logic [31:0] arr_rdata;

   // Zero-latency commits happen on the accept edge, so they use the live request.
   always_comb begin
      if (state_q == ST_IDLE) begin
         c_we    = req_we;
         c_addr  = req_addr;
         c_wdata = req_wdata;
         c_f3    = req_funct3;
      end else begin
         c_we    = we_q;
         c_addr  = addr_q;
         c_wdata = wdata_q;
         c_f3    = f3_q;
      end
   end

   always_comb begin
      c_range_err = (c_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
`ifdef DMEM_RSP_MISALIGN_TRAP_EN
      c_misalign = (((c_f3 == F3_H) || (c_f3 == F3_HU)) && c_addr[0]) ||
                   ((c_f3 == F3_W) && (c_addr[1:0] != 2'b00));
`else
      c_misalign = 1'b0;
`endif
      c_err = c_range_err || c_misalign || !f3_legal(c_we, c_f3);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      f3_d    = f3_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               f3_d    = req_funct3;
               if (LATENCY == 0) begin
                  commit  = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = CntLoad;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               commit  = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (commit) begin
         err_d   = c_err;
         rdata_d = (c_err || c_we) ? 32'd0 : ld_extend(arr_rdata, c_addr[1:0], c_f3);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   dmem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (commit && c_we && !c_err),
      .idx   (c_addr[DEPTH_LOG2+1:2]),
      .be    (st_mask(c_addr[1:0], c_f3)),
      .wdata (st_data(c_wdata, c_f3)),
      .rdata (arr_rdata)
   );

   assign req_ready = (state_q == ST_IDLE) && !reset;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench driving a LATENCY=0 and a LATENCY=3 responder in lockstep.
// Honours DMEM_RSP_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_ready;

   logic        req_ready_0, rsp_valid_0, rsp_err_0;
   logic        req_ready_3, rsp_valid_3, rsp_err_3;
   logic [31:0] rsp_rdata_0, rsp_rdata_3;

   int nchk  = 0;
   int npass = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_LOG2(5), .LATENCY(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready_0),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid_0),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata_0),
      .rsp_err    (rsp_err_0)
   );

   dmem_responder #(.DEPTH_LOG2(5), .LATENCY(3)) dut3 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready_3),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid_3),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata_3),
      .rsp_err    (rsp_err_3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request through both DUTs; latency counted in cycles after the accept cycle.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e,
                      input string tag, input int hold);
      int lat0;
      int lat3;
      int k;
      logic [31:0] d0;
      logic [31:0] d3;
      @(negedge clk);
      chk({tag, " ready0"}, {31'd0, req_ready_0}, 32'd1);
      chk({tag, " ready3"}, {31'd0, req_ready_3}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_funct3 = f3;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = ~we;
      req_addr   = 32'hFFFF_FFFC;
      req_wdata  = ~wdata;
      req_funct3 = 3'b111;
      lat0 = 0;
      lat3 = 0;
      k = 1;
      while (k <= 20) begin
         if (rsp_valid_0 && lat0 == 0) lat0 = k;
         if (rsp_valid_3 && lat3 == 0) lat3 = k;
         if (lat0 != 0 && lat3 != 0) break;
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, " lat0"}, 32'(lat0), 32'd1);
      chk({tag, " lat3"}, 32'(lat3), 32'd4);
      chk({tag, " rdata0"}, rsp_rdata_0, exp_d);
      chk({tag, " rdata3"}, rsp_rdata_3, exp_d);
      chk({tag, " err0"}, {31'd0, rsp_err_0}, {31'd0, exp_e});
      chk({tag, " err3"}, {31'd0, rsp_err_3}, {31'd0, exp_e});
      if (hold > 0) begin
         d0 = rsp_rdata_0;
         d3 = rsp_rdata_3;
         repeat (hold) @(posedge clk);
         #1;
         chk({tag, " hold valid3"}, {31'd0, rsp_valid_3}, 32'd1);
         chk({tag, " hold rdata0"}, rsp_rdata_0, exp_d);
         chk({tag, " hold rdata3"}, rsp_rdata_3, exp_d);
         chk({tag, " hold stable3"}, rsp_rdata_3 ^ d3, 32'd0);
         chk({tag, " hold stable0"}, rsp_rdata_0 ^ d0, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({tag, " done0"}, {31'd0, rsp_valid_0}, 32'd0);
      chk({tag, " done3"}, {31'd0, rsp_valid_3}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_funct3 = 3'd0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ready0", {31'd0, req_ready_0}, 32'd0);
      chk("rst ready3", {31'd0, req_ready_3}, 32'd0);
      chk("rst valid3", {31'd0, rsp_valid_3}, 32'd0);
      chk("rst rdata3", rsp_rdata_3, 32'd0);
      chk("rst err3", {31'd0, rsp_err_3}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post-rst ready3", {31'd0, req_ready_3}, 32'd1);

      txn(1'b0, 32'h00, 32'h0, 3'b010, 32'h0000_0000, 1'b0, "lw0 fresh", 0);
      txn(1'b1, 32'h04, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, "sw4", 0);
      txn(1'b0, 32'h07, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0, "lb7", 0);
      txn(1'b0, 32'h04, 32'h0, 3'b100, 32'h0000_00EF, 1'b0, "lbu4", 0);
      txn(1'b0, 32'h06, 32'h0, 3'b101, 32'h0000_DEAD, 1'b0, "lhu6", 0);
      txn(1'b1, 32'h05, 32'hAAAA_AA12, 3'b000, 32'h0, 1'b0, "sb5", 0);
      txn(1'b0, 32'h04, 32'h0, 3'b010, 32'hDEAD_12EF, 1'b0, "lw4 after sb", 0);
      txn(1'b1, 32'h00, 32'h8001_1234, 3'b010, 32'h0, 1'b0, "sw0", 0);
      txn(1'b1, 32'h80, 32'h5555_5555, 3'b010, 32'h0, 1'b1, "sw oob", 0);
      txn(1'b0, 32'h00, 32'h0, 3'b010, 32'h8001_1234, 1'b0, "lw0 after oob", 0);
`ifdef DMEM_RSP_MISALIGN_TRAP_EN
      txn(1'b0, 32'h03, 32'h0, 3'b001, 32'h0, 1'b1, "lh3 trap", 0);
`else
      txn(1'b0, 32'h03, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, "lh3 noalign", 0);
`endif
      txn(1'b0, 32'h04, 32'h0, 3'b011, 32'h0, 1'b1, "ld f3 011", 0);
      txn(1'b1, 32'h04, 32'h1111_1111, 3'b100, 32'h0, 1'b1, "st f3 100", 0);
      txn(1'b1, 32'h06, 32'hBBBB_5678, 3'b001, 32'h0, 1'b0, "sh6", 0);
      txn(1'b0, 32'h06, 32'h0, 3'b001, 32'h0000_5678, 1'b0, "lh6", 0);
`ifdef DMEM_RSP_MISALIGN_TRAP_EN
      txn(1'b0, 32'h06, 32'h0, 3'b010, 32'h0, 1'b1, "lw6 trap", 0);
`else
      txn(1'b0, 32'h06, 32'h0, 3'b010, 32'h5678_12EF, 1'b0, "lw6 noalign", 0);
`endif
      txn(1'b0, 32'h04, 32'h0, 3'b010, 32'h5678_12EF, 1'b0, "lw4 hold", 5);

      // Store that reset interrupts while the LATENCY=3 instance waits.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h08;
      req_wdata  = 32'hCAFE_F00D;
      req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("mid-wait valid3", {31'd0, rsp_valid_3}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("async drop valid0", {31'd0, rsp_valid_0}, 32'd0);
      chk("async drop valid3", {31'd0, rsp_valid_3}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      txn(1'b0, 32'h08, 32'h0, 3'b010, 32'h0000_0000, 1'b0, "lw8 after rst", 0);
      txn(1'b0, 32'h04, 32'h0, 3'b010, 32'h0000_0000, 1'b0, "lw4 cleared", 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
